// File: rtl/rah_tx_arbiter.sv
// Round-robin TX scheduler: grants one non-empty app FIFO at a time, emits a
// header word (length, app id) and then a burst of up to MAX_BURST payload words.
module rah_tx_arbiter #(
   parameter int unsigned TOTAL_APPS     = 8,
   parameter int unsigned APP_ID_WIDTH   = 3,
   parameter int unsigned DATA_WIDTH     = 48,
   parameter int unsigned FIFO_ADD_WIDTH = 10,
   parameter int unsigned MAX_BURST      = 256
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [TOTAL_APPS-1:0]                app_valid,
   input  logic [TOTAL_APPS*FIFO_ADD_WIDTH-1:0] app_count,
   input  logic [TOTAL_APPS*DATA_WIDTH-1:0]     app_data,
   output logic [TOTAL_APPS-1:0]                app_re,
   input  logic                                 tx_ready,
   output logic                                 tx_valid,
   output logic [DATA_WIDTH-1:0]                tx_data,
   output logic                                 tx_last,
   output logic                                 busy,
   output logic [APP_ID_WIDTH-1:0]              app_id
);

   localparam int unsigned RemW = $clog2(MAX_BURST) + 1;

   typedef enum logic [1:0] {StIdle, StArb, StHdr, StData} state_e;

   state_e                  state_q, state_d;
   logic [APP_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [APP_ID_WIDTH-1:0] app_id_q, app_id_d;
   logic [RemW-1:0]         remaining_q, remaining_d;

   logic [FIFO_ADD_WIDTH-1:0] count_arr [TOTAL_APPS];
   logic [DATA_WIDTH-1:0]     data_arr  [TOTAL_APPS];
   logic [TOTAL_APPS-1:0]     cand;

   always_comb begin
      for (int j = 0; j < int'(TOTAL_APPS); j++) begin
         count_arr[j] = app_count[j*FIFO_ADD_WIDTH +: FIFO_ADD_WIDTH];
         data_arr[j]  = app_data[j*DATA_WIDTH +: DATA_WIDTH];
         cand[j]      = app_valid[j] && (count_arr[j] != '0);
      end
   end

   // Split the scan into candidates above rr_ptr (preferred) and at/below it (wrap).
   logic                    found_hi, found_lo, any_cand;
   logic [APP_ID_WIDTH-1:0] sel_hi, sel_lo, sel;

   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      sel_hi   = '0;
      sel_lo   = '0;
      for (int j = 0; j < int'(TOTAL_APPS); j++) begin
         if (cand[j]) begin
            if (j > int'(rr_ptr_q)) begin
               if (!found_hi) begin
                  found_hi = 1'b1;
                  sel_hi   = APP_ID_WIDTH'(j);
               end
            end else if (!found_lo) begin
               found_lo = 1'b1;
               sel_lo   = APP_ID_WIDTH'(j);
            end
         end
      end
   end

   assign sel      = found_hi ? sel_hi : sel_lo;
   assign any_cand = |cand;

   logic [FIFO_ADD_WIDTH-1:0] sel_count;
   logic [RemW-1:0]           sel_len;

   always_comb begin
      sel_count = count_arr[sel];
      if (32'(sel_count) > MAX_BURST) begin
         sel_len = RemW'(MAX_BURST);
      end else begin
         sel_len = RemW'(sel_count);
      end
   end

   logic cur_valid, accept;

   assign cur_valid = app_valid[app_id_q];
   assign accept    = (state_q == StData) && cur_valid && tx_ready;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      app_id_d    = app_id_q;
      remaining_d = remaining_q;
      unique case (state_q)
         StIdle: begin
            if (any_cand) state_d = StArb;
         end
         StArb: begin
            if (any_cand) begin
               app_id_d    = sel;
               remaining_d = sel_len;
               state_d     = StHdr;
            end else begin
               state_d = StIdle;
            end
         end
         StHdr: begin
            if (tx_ready) state_d = StData;
         end
         StData: begin
            if (accept) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == RemW'(1)) begin
                  rr_ptr_d = app_id_q;
                  state_d  = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= APP_ID_WIDTH'(TOTAL_APPS - 1);
         app_id_q    <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         app_id_q    <= app_id_d;
         remaining_q <= remaining_d;
      end
   end

   // Outputs decode from registered state; DATA-phase valid follows the FIFO so
   // an underflowing queue stalls the stream instead of emitting stale words.
   logic [31:0]           rem_ext;
   logic [DATA_WIDTH-1:0] hdr_word;

   always_comb begin
      rem_ext                          = 32'(remaining_q);
      hdr_word                         = '0;
      hdr_word[APP_ID_WIDTH-1:0]       = app_id_q;
      hdr_word[APP_ID_WIDTH +: 16]     = rem_ext[15:0];
   end

   always_comb begin
      app_re   = '0;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = '0;
      unique case (state_q)
         StHdr: begin
            tx_valid = 1'b1;
            tx_data  = hdr_word;
         end
         StData: begin
            tx_valid         = cur_valid;
            tx_data          = data_arr[app_id_q];
            tx_last          = (remaining_q == RemW'(1));
            app_re[app_id_q] = cur_valid && tx_ready;
         end
         default: ;
      endcase
   end

   assign busy   = (state_q != StIdle);
   assign app_id = app_id_q;

endmodule

// File: doc/rah_tx_arbiter.md
Name: rah_tx_arbiter

Overview:
- Round-robin scheduler that shares the single host-bound TX stream between TOTAL_APPS per-application data FIFOs.
- Picks one non-empty app FIFO and emits a header word (app ID, length), then a burst of up to MAX_BURST words popped from that FIFO.
- Releases the stream and rotates priority after each burst.
- Sits between the per-app FWFT data queues and the host TX framer. It is the write-direction counterpart of the read-request queue.

Parameters:
- TOTAL_APPS, 8, number of application FIFOs.
- APP_ID_WIDTH, 3, width of app index; must satisfy 2**APP_ID_WIDTH >= TOTAL_APPS.
- DATA_WIDTH, 48, TX word width; must be >= APP_ID_WIDTH+16.
- FIFO_ADD_WIDTH, 10, width of each FIFO occupancy count.
- MAX_BURST, 256, maximum data words per burst; must be <= 65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- app_valid  in  TOTAL_APPS  per-app FIFO non-empty (~empty).
- app_count  in  TOTAL_APPS*FIFO_ADD_WIDTH  per-app occupancy; app i at [i*FIFO_ADD_WIDTH +: FIFO_ADD_WIDTH].
- app_data  in  TOTAL_APPS*DATA_WIDTH  per-app FWFT head word; app i at [i*DATA_WIDTH +: DATA_WIDTH].
- app_re  out  TOTAL_APPS  one-hot pop strobe to the granted FIFO.
- tx_ready  in  1  downstream accepts a word this cycle.
- tx_valid  out  1  word on tx_data is valid.
- tx_data  out  DATA_WIDTH  header or payload word.
- tx_last  out  1  final payload word of the burst.
- busy  out  1  high while state != IDLE.
- app_id  out  APP_ID_WIDTH  index of the current or most recent grant.

Behaviour:
- Reset (async, any state, including mid-burst):
  - state=IDLE, rr_ptr=TOTAL_APPS-1, so app 0 has first priority.
  - app_id=0, remaining=0.
  - Outputs app_re=0, tx_valid=0, tx_last=0, tx_data=0, busy=0.
  - Any partial burst is abandoned; no header or data is replayed.
- Eligibility: app i is a candidate iff app_valid[i] && app_count[i]!=0. An app with valid but zero count is ignored.
- States: IDLE, ARB, HDR, DATA.
- IDLE:
  - If any candidate exists -> ARB next cycle; otherwise stay in IDLE.
  - No outputs asserted.
- ARB (1 cycle):
  - Select the first candidate scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo TOTAL_APPS.
  - Register app_id=sel and remaining=min(app_count[sel], MAX_BURST). remaining is $clog2(MAX_BURST)+1 bits wide.
  - Go to HDR.
  - If no candidate remains (eligibility dropped since IDLE), return to IDLE with app_id unchanged.
- HDR:
  - tx_valid=1, tx_last=0.
  - tx_data = {zeros, remaining[15:0] zero-extended, app_id}: app_id in bits [APP_ID_WIDTH-1:0], length in [APP_ID_WIDTH+15:APP_ID_WIDTH].
  - Hold until tx_ready=1, then go to DATA. No pop occurs in HDR.
- DATA:
  - tx_valid = app_valid[app_id]. An underflowing FIFO stalls the stream; it never emits garbage.
  - tx_data = app_data[app_id]; tx_last = (remaining==1).
  - app_re[app_id] = tx_valid && tx_ready (combinational); all other app_re bits stay 0.
  - On each accepted word, decrement remaining.
  - On the accepted word with remaining==1: rr_ptr<=app_id, then IDLE. The next ARB therefore earliest occurs 2 cycles after the last word.
- Latency:
  - Candidate appears while IDLE -> header on tx_data 2 cycles later (IDLE->ARB->HDR).
  - Each accepted word costs exactly one cycle when tx_ready and app_valid are held high.
- Burst length: the sampled count is frozen in ARB. Words arriving in that FIFO during the burst wait for a later grant.
- tx_data in IDLE/ARB: driven 0.
- No requester is starved: after a grant to app k, all other candidates are scanned before k again.
- Occupancy greater than MAX_BURST: clipped to MAX_BURST. The remainder is served on a later round once other candidates have had their turn.

Test Plan:
- Reset, then app 2 only valid with count=3, tx_ready=1 -> header {len=3, id=2} 2 cycles after request, then 3 words. tx_last on the 3rd word; app_re=0b00000100 for exactly 3 cycles; busy drops after.
- Apps 1, 4, 6 valid with count=2 each, persistent -> grant order 1, 4, 6, 1, ... For each: header + 2 words; app_id matches the header field every burst.
- App 0 count=600, MAX_BURST=256 -> headers len=256, 256, then len=88 in successive bursts. Each burst is followed by an idle gap ≥2 cycles.
- tx_ready toggled 1/0 every cycle during a 4-word burst -> no pops or state advance while tx_ready=0. Words arrive in order, exactly 4 pops, tx_last only on the 4th.
- app_valid[3] drops for 5 cycles mid-burst -> tx_valid=0 and app_re=0 for those cycles. The burst resumes with the correct remaining count.
- rst asserted mid-DATA with remaining=10 -> all outputs 0 immediately (asynchronously). After release, app 0 wins over app 5 when both are valid.
